// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: window defaults and the bus entry layout used by the
// store buffer, the peripheral decoder and the core testbench.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h4000_0000;
    localparam logic [31:0] MMIO_MASK_DEF = 32'hF000_0000;
    localparam int          ENTRY_W       = 64;

    // One queued store: addr in [63:32], data in [31:0].
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } bus_entry_t;

    // Address falls in the MMIO window.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO. The read port is driven straight from
// storage and pointer registers, so it has no combinational path from the write side.
// full/empty are registered from the next-state count.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]              count_q, count_d;
    logic                        full_q, empty_q;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers (wrap modulo DEPTH) and registered status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/mmio_store_buffer.sv
// MMIO store buffer: captures core stores that hit the MMIO window, queues
// them and drains them to the peripheral bus over valid/ready. The core never
// stalls, so stores arriving while full are dropped and counted.
module mmio_store_buffer
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [31:0] MMIO_MASK = MMIO_MASK_DEF,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             bus_valid,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_data,
    input  logic             bus_ready,
    input  logic             clear_ovf,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             hit, push, pop, drop;
    bus_entry_t       wr_entry, rd_entry;
    logic             fifo_full, fifo_empty;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign hit   = MemWrite && in_window(DataAdr, MMIO_BASE, MMIO_MASK);
    assign pop   = bus_valid && bus_ready;
    // When full, a concurrent pop frees the slot this push lands in.
    assign push  = hit && (!fifo_full || pop);
    assign drop  = hit && fifo_full && !pop;

    assign wr_entry = '{addr: DataAdr, data: WriteData};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Drop bookkeeping; a drop in the same cycle as clear_ovf wins and counts as the first.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_ovf)                drop_cnt_d = CNT_ONE;
            else if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus_valid  = !fifo_empty;
    assign bus_addr   = rd_entry.addr;
    assign bus_data   = rd_entry.data;
    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_mmio_store_buffer.sv
// Scoreboard bench for mmio_store_buffer: accepted stores push their expected
// bus entry into a queue; a monitor compares every bus handshake against it.
module tb_mmio_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] DataAdr, WriteData;
    logic        bus_valid;
    logic [31:0] bus_addr, bus_data;
    logic        bus_ready, clear_ovf;
    logic        full, empty, overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mmio_store_buffer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_ready(bus_ready), .clear_ovf(clear_ovf),
        .full(full), .empty(empty), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a handshake is committed at the next rising edge, so compare at negedge.
    always @(negedge clk) begin
        if (rst && bus_valid && bus_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pop: got %h/%h expected nothing", bus_addr, bus_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus_addr, bus_data} !== e) begin
                    n_fail++;
                    $display("FAIL pop_order: got %h/%h expected %h/%h",
                             bus_addr, bus_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle store; the bench decides whether it expects the store on the bus.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit accept);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        if (accept) exp_q.push_back({a, d});
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        bus_ready = 1'b1;
        k = 0;
        while (!empty && k < 20) begin
            step();
            k++;
        end
        check({name, "_empty"}, {31'd0, empty}, 32'd1);
        check({name, "_queue"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        bus_ready = 1'b0; clear_ovf = 1'b0;
        step(); step();
        check("rst_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full}, 32'd0);
        check("rst_addr",  bus_addr, 32'd0);
        check("rst_data",  bus_data, 32'd0);
        check("rst_drop",  {24'd0, drop_count}, 32'd0);
        rst = 1'b1;
        step();

        // Single store, latency one cycle, gone one cycle later.
        bus_ready = 1'b1;
        store(32'h4000_0010, 32'hDEADBEEF, 1'b1);
        check("single_valid", {31'd0, bus_valid}, 32'd1);
        check("single_addr", bus_addr, 32'h4000_0010);
        check("single_data", bus_data, 32'hDEADBEEF);
        step();
        check("single_gone", {31'd0, bus_valid}, 32'd0);

        // RAM store is ignored.
        store(32'h0000_0020, 32'h1111_2222, 1'b0);
        check("filter_valid", {31'd0, bus_valid}, 32'd0);
        check("filter_empty", {31'd0, empty}, 32'd1);

        // Backpressure: fill, drop the fifth, head stable, drain in order.
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            store(32'h4000_0000 + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b1);
        check("bp_full", {31'd0, full}, 32'd1);
        store(32'h4000_0010, 32'hA000_0004, 1'b0);
        check("bp_ovf",  {31'd0, overflow}, 32'd1);
        check("bp_drop", {24'd0, drop_count}, 32'd1);
        check("bp_head", bus_addr, 32'h4000_0000);
        step();
        check("bp_head_stable", bus_data, 32'hA000_0000);
        drain("bp");

        // Full with simultaneous push and pop: nothing dropped.
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            store(32'h4000_0020 + 32'(4*i), 32'hB000_0000 + 32'(i), 1'b1);
        bus_ready = 1'b1;
        store(32'h4000_0100, 32'hB000_0100, 1'b1);
        check("pp_full", {31'd0, full}, 32'd1);
        check("pp_drop", {24'd0, drop_count}, 32'd1);
        check("pp_head", bus_addr, 32'h4000_0024);
        drain("pp");

        // clear_ovf vs concurrent drop, then alone, then saturation.
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            store(32'h4000_0040 + 32'(4*i), 32'hC000_0000 + 32'(i), 1'b1);
        clear_ovf = 1'b1;
        store(32'h4000_0050, 32'hC000_0004, 1'b0);
        clear_ovf = 1'b0;
        check("clr_drop_ovf", {31'd0, overflow}, 32'd1);
        check("clr_drop_cnt", {24'd0, drop_count}, 32'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_cnt", {24'd0, drop_count}, 32'd0);
        for (int i = 0; i < 300; i++)
            store(32'h4000_0060, 32'(i), 1'b0);
        check("sat_cnt", {24'd0, drop_count}, 32'h0000_00FF);
        check("sat_ovf", {31'd0, overflow}, 32'd1);
        drain("sat");

        // Reset mid-run with two entries queued.
        bus_ready = 1'b0;
        store(32'h4000_0080, 32'hD000_0000, 1'b1);
        store(32'h4000_0084, 32'hD000_0001, 1'b1);
        check("mid_valid_pre", {31'd0, bus_valid}, 32'd1);
        rst = 1'b0;
        exp_q.delete();
        step();
        check("mid_valid", {31'd0, bus_valid}, 32'd0);
        check("mid_empty", {31'd0, empty}, 32'd1);
        check("mid_ovf",   {31'd0, overflow}, 32'd0);
        check("mid_drop",  {24'd0, drop_count}, 32'd0);
        rst = 1'b1;
        bus_ready = 1'b1;
        step(); step();
        check("post_rst_valid", {31'd0, bus_valid}, 32'd0);
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
